// File: rtl/laser_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// laser_scan_ctrl : two-centre radius-4 laser coverage search sequencer
// Revision        : 1.0
// =============================================================================
module laser_scan_ctrl #(
    parameter int CNT_W    = 6,
    parameter int MAX_PASS = 15
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             CAND_READY,
    output logic             CAND_VALID,
    output logic [3:0]       CAND_X,
    output logic [3:0]       CAND_Y,
    input  logic             CNT_VALID,
    input  logic [CNT_W-1:0] CNT,
    output logic             MASK_REQ,
    output logic [3:0]       MASK_X,
    output logic [3:0]       MASK_Y,
    input  logic             MASK_DONE,
    output logic [3:0]       C1X,
    output logic [3:0]       C1Y,
    output logic [3:0]       C2X,
    output logic [3:0]       C2Y,
    output logic [CNT_W-1:0] BEST_CNT,
    output logic [3:0]       PASS_NUM,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MASK   = 3'd1,
        S_SWEEP  = 3'd2,
        S_DRAIN  = 3'd3,
        S_UPDATE = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       c1;
    logic [7:0]       c2;
    logic [CNT_W-1:0] best_cnt;
    logic [3:0]       pass_num;
    logic             stable;
    logic             target;       // 0 = optimising C1, 1 = optimising C2
    logic [8:0]       issue_idx;
    logic [8:0]       ret_idx;
    logic [CNT_W-1:0] best;
    logic [7:0]       best_idx;

    logic             xfer;
    logic             ret_ok;
    logic [7:0]       tgt_idx;
    logic             changed;
    logic [3:0]       pass_inc;
    logic             finish_now;

    assign xfer       = (state == S_SWEEP) && CAND_READY;
    // Returns beyond the 256th of a sweep are not expected; they are dropped.
    assign ret_ok     = CNT_VALID && ((state == S_SWEEP) || (state == S_DRAIN)) && !ret_idx[8];
    assign tgt_idx    = target ? c2 : c1;
    assign changed    = (best_idx != tgt_idx);
    assign pass_inc   = pass_num + 4'd1;
    assign finish_now = (!changed && stable) || (pass_inc == 4'(MAX_PASS));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (START)     state_nxt = S_MASK;
            S_MASK:   if (MASK_DONE) state_nxt = S_SWEEP;
            S_SWEEP:  if (xfer && (issue_idx == 9'd255)) state_nxt = S_DRAIN;
            S_DRAIN:  if (ret_idx[8] || (ret_ok && (ret_idx == 9'd255))) state_nxt = S_UPDATE;
            S_UPDATE: state_nxt = finish_now ? S_FINISH : S_MASK;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            c1        <= 8'd0;
            c2        <= 8'd0;
            best_cnt  <= '0;
            pass_num  <= 4'd0;
            stable    <= 1'b0;
            target    <= 1'b0;
            issue_idx <= 9'd0;
            ret_idx   <= 9'd0;
            best      <= '0;
            best_idx  <= 8'd0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        pass_num <= 4'd0;
                        stable   <= 1'b0;
                        target   <= 1'b0;
                    end
                end
                S_MASK: begin
                    if (MASK_DONE) begin
                        issue_idx <= 9'd0;
                        ret_idx   <= 9'd0;
                        best      <= '0;
                        best_idx  <= 8'd0;
                    end
                end
                S_UPDATE: begin
                    if (target) c2 <= best_idx;
                    else        c1 <= best_idx;
                    best_cnt <= best;
                    pass_num <= pass_inc;
                    if (!finish_now) begin
                        stable <= !changed;
                        target <= !target;
                    end
                end
                default: ;
            endcase
            if (xfer) issue_idx <= issue_idx + 9'd1;
            // ">=" makes ties resolve to the latest (highest) index.
            if (ret_ok) begin
                if (CNT >= best) begin
                    best     <= CNT;
                    best_idx <= ret_idx[7:0];
                end
                ret_idx <= ret_idx + 9'd1;
            end
        end
    end

    assign CAND_VALID = (state == S_SWEEP);
    assign CAND_X     = issue_idx[3:0];
    assign CAND_Y     = issue_idx[7:4];
    assign MASK_REQ   = (state == S_MASK);
    assign MASK_X     = target ? c1[3:0] : c2[3:0];
    assign MASK_Y     = target ? c1[7:4] : c2[7:4];
    assign C1X        = c1[3:0];
    assign C1Y        = c1[7:4];
    assign C2X        = c2[3:0];
    assign C2Y        = c2[7:4];
    assign BEST_CNT   = best_cnt;
    assign PASS_NUM   = pass_num;
    assign BUSY       = (state == S_MASK) || (state == S_SWEEP) ||
                        (state == S_DRAIN) || (state == S_UPDATE);
    assign DONE       = (state == S_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_laser_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// tb_laser_scan_ctrl : table-driven bench with a behavioural bitmap/count model
// Revision           : 1.0
// =============================================================================
module tb_laser_scan_ctrl;

    localparam int CNT_W = 6;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             START = 1'b0;
    logic             CAND_READY = 1'b0;
    logic             CNT_VALID = 1'b0;
    logic [CNT_W-1:0] CNT = '0;
    logic             MASK_DONE = 1'b0;
    logic             CAND_VALID, MASK_REQ, BUSY, DONE;
    logic [3:0]       CAND_X, CAND_Y, MASK_X, MASK_Y, C1X, C1Y, C2X, C2Y, PASS_NUM;
    logic [CNT_W-1:0] BEST_CNT;

    laser_scan_ctrl #(.CNT_W(CNT_W), .MAX_PASS(15)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START),
        .CAND_READY(CAND_READY), .CAND_VALID(CAND_VALID), .CAND_X(CAND_X), .CAND_Y(CAND_Y),
        .CNT_VALID(CNT_VALID), .CNT(CNT),
        .MASK_REQ(MASK_REQ), .MASK_X(MASK_X), .MASK_Y(MASK_Y), .MASK_DONE(MASK_DONE),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .BEST_CNT(BEST_CNT), .PASS_NUM(PASS_NUM), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int mode;   // 0 empty, 1 two peaks, 2 ties, 3 best flips every sweep
        int rdy;    // 0 always ready, 1 ready one cycle in three
        int lat;
        int c1x, c1y, c2x, c2y, best, pass;
    } vec_t;

    vec_t       tbl[5];
    int         compared = 0;
    int         mismatched = 0;
    int         mode = 0, rdy_mode = 0, lat = 1, cyc = 0;
    int         sweep_no = 0, transfers = 0, dones = 0, exp_issue = 0;
    logic [7:0] mask_idx = 8'd0;
    int         due_q[$];
    logic [7:0] idx_q[$];
    bit         inject = 1'b0, mask_wait = 1'b0, prev_valid = 1'b0, prev_xfer = 1'b0;
    logic [3:0] prev_x = 4'd0, prev_y = 4'd0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Points covered by the mask centre read as zero.
    function automatic logic [CNT_W-1:0] model(input int m, input logic [7:0] i,
                                               input logic [7:0] mk, input int sw);
        logic [7:0] swb;
        swb = sw[7:0];
        if (i == mk) return '0;
        case (m)
            1: return (i == 8'h37) ? 6'd9 : (i == 8'hA2) ? 6'd5 : 6'd0;
            2: return ((i == 8'h10) || (i == 8'h80)) ? 6'd4 : 6'd0;
            3: return (i == swb) ? 6'd3 : 6'd0;
            default: return '0;
        endcase
    endfunction

    // Datapath and bitmap responder: everything is sampled and driven on negedge.
    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            CNT_VALID = 1'b0;
            CNT       = '0;
            if (inject) begin
                CNT_VALID = 1'b1;
                CNT       = 6'd63;
                inject    = 1'b0;
            end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
                CNT_VALID = 1'b1;
                CNT       = model(mode, idx_q[0], mask_idx, sweep_no);
                void'(due_q.pop_front());
                void'(idx_q.pop_front());
            end
            CAND_READY = (rdy_mode == 0) || (cyc % 3 == 0);
            if (CAND_VALID) begin
                if (prev_valid && !prev_xfer) begin
                    check("stall_hold_x", CAND_X, prev_x);
                    check("stall_hold_y", CAND_Y, prev_y);
                end
                if (CAND_READY) begin
                    check("issue_order", {CAND_Y, CAND_X}, exp_issue);
                    exp_issue++;
                    transfers++;
                    due_q.push_back(cyc + lat);
                    idx_q.push_back({CAND_Y, CAND_X});
                end
            end
            prev_valid = CAND_VALID;
            prev_xfer  = CAND_VALID && CAND_READY;
            prev_x     = CAND_X;
            prev_y     = CAND_Y;
            MASK_DONE  = 1'b0;
            if (MASK_REQ) begin
                if (!mask_wait) mask_wait = 1'b1;
                else begin
                    MASK_DONE = 1'b1;
                    mask_wait = 1'b0;
                    mask_idx  = {MASK_Y, MASK_X};
                    sweep_no++;
                    exp_issue = 0;
                end
            end else mask_wait = 1'b0;
            if (DONE) dones++;
        end
    end

    task automatic prep(input vec_t v);
        mode = v.mode; rdy_mode = v.rdy; lat = v.lat;
        transfers = 0; dones = 0; sweep_no = 0;
        due_q.delete(); idx_q.delete();
    endtask

    task automatic run_case(input vec_t v, input string tag);
        int n;
        prep(v);
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        check({tag, "_busy_after_start"}, BUSY, 1);
        n = 0;
        while (!DONE && n < 30000) begin
            @(negedge CLK);
            n++;
        end
        if (!DONE) begin
            check({tag, "_done_timeout"}, 0, 1);
        end else begin
            check({tag, "_c1x"}, C1X, v.c1x);
            check({tag, "_c1y"}, C1Y, v.c1y);
            check({tag, "_c2x"}, C2X, v.c2x);
            check({tag, "_c2y"}, C2Y, v.c2y);
            check({tag, "_best_cnt"}, BEST_CNT, v.best);
            check({tag, "_pass_num"}, PASS_NUM, v.pass);
            check({tag, "_busy_at_done"}, BUSY, 0);
            @(negedge CLK);
            check({tag, "_done_width"}, DONE, 0);
            @(negedge CLK);
            check({tag, "_done_pulses"}, dones, 1);
            check({tag, "_transfers"}, transfers, 256 * v.pass);
            check({tag, "_hold_pass"}, PASS_NUM, v.pass);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_c1"}, {C1Y, C1X}, 0);
        check({tag, "_c2"}, {C2Y, C2X}, 0);
        check({tag, "_best_cnt"}, BEST_CNT, 0);
        check({tag, "_pass_num"}, PASS_NUM, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_done"}, DONE, 0);
        check({tag, "_cand_valid"}, CAND_VALID, 0);
        check({tag, "_mask_req"}, MASK_REQ, 0);
    endtask

    initial begin
        int n;
        tbl[0] = '{mode: 0, rdy: 0, lat: 1, c1x: 15, c1y: 15, c2x: 15, c2y: 15, best: 0, pass: 4};
        tbl[1] = '{mode: 1, rdy: 0, lat: 1, c1x: 7,  c1y: 3,  c2x: 2,  c2y: 10, best: 5, pass: 4};
        tbl[2] = '{mode: 2, rdy: 0, lat: 2, c1x: 0,  c1y: 8,  c2x: 0,  c2y: 1,  best: 4, pass: 4};
        tbl[3] = '{mode: 1, rdy: 1, lat: 5, c1x: 7,  c1y: 3,  c2x: 2,  c2y: 10, best: 5, pass: 4};
        tbl[4] = '{mode: 3, rdy: 0, lat: 3, c1x: 15, c1y: 0,  c2x: 14, c2y: 0,  best: 3, pass: 15};

        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST_N = 1'b1;

        for (int i = 0; i < 5; i++) run_case(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of the second sweep, then a stray count in IDLE.
        prep(tbl[1]);
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        n = 0;
        while (transfers < 300 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        check("midrst_reached_sweep", (transfers >= 300) ? 1 : 0, 1);
        RST_N = 1'b0;
        @(negedge CLK);
        check_all_zero("midrst");
        RST_N  = 1'b1;
        inject = 1'b1;
        repeat (8) @(negedge CLK);
        check_all_zero("stray");
        run_case(tbl[1], "rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
